// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FPU definitions used by the multiplier and the adder:
//   - fpu_state_e : execute-stage FSM states
//   - fpu_class_e : operand classes (zero / normal / inf / NaN)
//   - fpu_bias()  : exponent bias, 2^(EXP_W-1)-1
//   - fpu_emax()  : all-ones exponent code, 2^EXP_W-1
//   - fpu_classify() : operand classification from field summaries
// The canonical quiet NaN is sign 0 with exponent and fraction all ones.
// -----------------------------------------------------------------------------
package fpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_NORM  = 3'd2,
      ST_ROUND = 3'd3,
      ST_DONE  = 3'd4
   } fpu_state_e;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_NORMAL = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fpu_class_e;

   function automatic int fpu_bias(input int exp_w);
      return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
   endfunction

   function automatic int fpu_emax(input int exp_w);
      return (32'sd1 <<< exp_w) - 32'sd1;
   endfunction

   // Subnormals (exp == 0) are treated as zero; the caller supplies the
   // field summaries so the function is independent of the format width.
   function automatic fpu_class_e fpu_classify(input logic exp_zero,
                                               input logic exp_ones,
                                               input logic frac_zero);
      fpu_class_e cls_v;
      if (exp_zero) begin
         cls_v = CLS_ZERO;
      end else if (exp_ones) begin
         cls_v = frac_zero ? CLS_INF : CLS_NAN;
      end else begin
         cls_v = CLS_NORMAL;
      end
      return cls_v;
   endfunction

endpackage

// File: rtl/fpu_multiplier_rne_if.sv
// -----------------------------------------------------------------------------
// fpu_multiplier_rne_if
// Operand/result bundle for the FPU multiplier.
//   data_valid_i / ready_o : input handshake (accept on both high at clk edge)
//   x_i, y_i               : packed operands {sign, exp, frac}
//   data_valid_o           : one-cycle result strobe
//   z_o                    : packed result
//   except_*_o             : invalid / overflow / underflow / inexact flags
// Modports: master drives operands, slave is the multiplier.
// -----------------------------------------------------------------------------
interface fpu_multiplier_rne_if #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
);
   localparam int W = 1 + EXP_W + FRAC_W;

   logic          data_valid_i;
   logic          ready_o;
   logic [W-1:0]  x_i;
   logic [W-1:0]  y_i;
   logic          data_valid_o;
   logic [W-1:0]  z_o;
   logic          except_invalid_operation_o;
   logic          except_overflow_o;
   logic          except_underflow_o;
   logic          except_inexact_o;

   modport master (
      output data_valid_i, x_i, y_i,
      input  ready_o, data_valid_o, z_o,
      input  except_invalid_operation_o, except_overflow_o,
      input  except_underflow_o, except_inexact_o
   );

   modport slave (
      input  data_valid_i, x_i, y_i,
      output ready_o, data_valid_o, z_o,
      output except_invalid_operation_o, except_overflow_o,
      output except_underflow_o, except_inexact_o
   );
endinterface

// File: rtl/fpu_rounder.sv
// -----------------------------------------------------------------------------
// fpu_rounder
// Combinational mantissa rounder shared by the FPU multiplier and adder.
//   mant_i   : fraction bits kept after normalisation (hidden bit excluded)
//   guard_i  : first discarded bit
//   sticky_i : OR of all further discarded bits
//   exp_i    : signed biased exponent
//   mant_o   : rounded fraction
//   exp_o    : exponent incremented on mantissa carry-out
//   carry_o  : rounding overflowed the fraction field
// Config macro FPU_MUL_ROUND_EN: defined -> round-to-nearest-even,
// undefined -> truncation (never increments).
// -----------------------------------------------------------------------------
module fpu_rounder #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 10
) (
   input  logic [MANT_W-1:0]       mant_i,
   input  logic                    guard_i,
   input  logic                    sticky_i,
   input  logic signed [EXP_W-1:0] exp_i,
   output logic [MANT_W-1:0]       mant_o,
   output logic signed [EXP_W-1:0] exp_o,
   output logic                    carry_o
);

`ifdef FPU_MUL_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   logic              inc_s;
   logic [MANT_W:0]   sum_s;

   // Increment on tie-to-even rule; a carry-out wraps the fraction to zero
   // and bumps the exponent (1.111..1 + ulp = 10.000..0).
   always_comb begin
      inc_s   = ROUND_EN & guard_i & (sticky_i | mant_i[0]);
      sum_s   = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc_s};
      carry_o = sum_s[MANT_W];
      mant_o  = sum_s[MANT_W-1:0];
      exp_o   = exp_i + $signed({{(EXP_W-1){1'b0}}, sum_s[MANT_W]});
   end

endmodule

// File: rtl/fpu_multiplier_rne.sv
// -----------------------------------------------------------------------------
// fpu_multiplier_rne
// Parametrised floating-point multiplier with fixed 4-cycle latency.
// Operands are classified internally (subnormals flush to zero).
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : fpu_multiplier_rne_if.slave (handshake, operands, result, flags)
// FSM IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE; an operand accepted at
// edge T presents data_valid_o during the DONE cycle, i.e. after edge T+3.
// Config macro FPU_MUL_ROUND_EN (used in fpu_rounder): defined ->
// round-to-nearest-even, undefined -> truncation with unchanged latency.
// -----------------------------------------------------------------------------
module fpu_multiplier_rne
   import fpu_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fpu_multiplier_rne_if.slave  bus
);

   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int MW = FRAC_W + 1;          // mantissa with hidden bit
   localparam int PW = 2 * MW;              // full product width
   localparam int EW = EXP_W + 2;           // signed working exponent

   localparam logic signed [EW-1:0] BIAS_S = EW'(fpu_bias(EXP_W));
   localparam logic signed [EW-1:0] EMAX_S = EW'(fpu_emax(EXP_W));
   localparam logic signed [EW-1:0] ONE_S  = EW'(32'sd1);
   localparam logic signed [EW-1:0] ZERO_S = EW'(32'sd0);
   localparam logic [W-1:0]         QNAN   = {1'b0, {(W-1){1'b1}}};

   // ---------------- registers ----------------
   fpu_state_e               state_r;
   logic                     ready_r;
   logic                     dv_r;
   logic [W-1:0]             z_r;
   logic                     inv_r, ovf_r, unf_r, inx_r;

   logic                     sign_r;
   fpu_class_e               xcls_r, ycls_r;
   logic signed [EW-1:0]     exp_r;
   logic [MW-1:0]            xm_r, ym_r;
   logic [PW-1:0]            prod_r;
   logic [FRAC_W-1:0]        frac_r;
   logic                     guard_r, sticky_r;

   // ---------------- combinational ----------------
   logic [EXP_W-1:0]         x_exp_s, y_exp_s;
   logic [FRAC_W-1:0]        x_frac_s, y_frac_s;
   fpu_class_e               x_cls_s, y_cls_s;

   logic [FRAC_W-1:0]        norm_frac_s;
   logic                     norm_guard_s, norm_sticky_s;
   logic signed [EW-1:0]     norm_exp_s;

   logic [FRAC_W-1:0]        rnd_mant_s;
   logic signed [EW-1:0]     rnd_exp_s;
   logic                     rnd_carry_s;

   logic [W-1:0]             res_z_s;
   logic                     res_inv_s, res_ovf_s, res_unf_s, res_inx_s;
   logic                     any_nan_s, any_inf_s, any_zero_s;

   // Field extraction and classification of the incoming operands.
   always_comb begin
      x_exp_s  = bus.x_i[W-2 -: EXP_W];
      y_exp_s  = bus.y_i[W-2 -: EXP_W];
      x_frac_s = bus.x_i[FRAC_W-1:0];
      y_frac_s = bus.y_i[FRAC_W-1:0];
      x_cls_s  = fpu_classify(x_exp_s == {EXP_W{1'b0}},
                              x_exp_s == {EXP_W{1'b1}},
                              x_frac_s == {FRAC_W{1'b0}});
      y_cls_s  = fpu_classify(y_exp_s == {EXP_W{1'b0}},
                              y_exp_s == {EXP_W{1'b1}},
                              y_frac_s == {FRAC_W{1'b0}});
   end

   // Normalisation: the product of two [1,2) mantissas lies in [1,4); when
   // the top bit is set the binary point moves one place left.
   always_comb begin
      if (prod_r[PW-1]) begin
         norm_frac_s   = prod_r[PW-2 -: FRAC_W];
         norm_guard_s  = prod_r[PW-2-FRAC_W];
         norm_sticky_s = |prod_r[PW-3-FRAC_W:0];
         norm_exp_s    = exp_r + ONE_S;
      end else begin
         norm_frac_s   = prod_r[PW-3 -: FRAC_W];
         norm_guard_s  = prod_r[PW-3-FRAC_W];
         norm_sticky_s = |prod_r[PW-4-FRAC_W:0];
         norm_exp_s    = exp_r;
      end
   end

   fpu_rounder #(
      .MANT_W (FRAC_W),
      .EXP_W  (EW)
   ) u_rounder (
      .mant_i   (frac_r),
      .guard_i  (guard_r),
      .sticky_i (sticky_r),
      .exp_i    (exp_r),
      .mant_o   (rnd_mant_s),
      .exp_o    (rnd_exp_s),
      .carry_o  (rnd_carry_s)
   );

   // Result selection: special operands first, then range check of the
   // rounded exponent, otherwise the packed arithmetic result.
   always_comb begin
      any_nan_s  = (xcls_r == CLS_NAN)  || (ycls_r == CLS_NAN);
      any_inf_s  = (xcls_r == CLS_INF)  || (ycls_r == CLS_INF);
      any_zero_s = (xcls_r == CLS_ZERO) || (ycls_r == CLS_ZERO);

      // On carry-out the fraction is already zero; selecting it explicitly
      // keeps the packed field independent of the adder's summation width.
      res_z_s   = {sign_r, rnd_exp_s[EXP_W-1:0],
                   rnd_carry_s ? {FRAC_W{1'b0}} : rnd_mant_s};
      res_inv_s = 1'b0;
      res_ovf_s = 1'b0;
      res_unf_s = 1'b0;
      res_inx_s = guard_r | sticky_r;

      if (any_nan_s || (any_inf_s && any_zero_s)) begin
         res_z_s   = QNAN;
         res_inv_s = 1'b1;
         res_inx_s = 1'b0;
      end else if (any_inf_s) begin
         res_z_s   = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         res_inx_s = 1'b0;
      end else if (any_zero_s) begin
         res_z_s   = {sign_r, {(W-1){1'b0}}};
         res_inx_s = 1'b0;
      end else if (rnd_exp_s >= EMAX_S) begin
         res_z_s   = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         res_ovf_s = 1'b1;
         res_inx_s = 1'b1;
      end else if (rnd_exp_s <= ZERO_S) begin
         res_z_s   = {sign_r, {(W-1){1'b0}}};
         res_unf_s = 1'b1;
         res_inx_s = 1'b1;
      end else begin
         res_inv_s = 1'b0;
      end
   end

   // Control FSM with datapath pipeline registers and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         ready_r  <= 1'b1;
         dv_r     <= 1'b0;
         z_r      <= {W{1'b0}};
         inv_r    <= 1'b0;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
         inx_r    <= 1'b0;
         sign_r   <= 1'b0;
         xcls_r   <= CLS_ZERO;
         ycls_r   <= CLS_ZERO;
         exp_r    <= ZERO_S;
         xm_r     <= {MW{1'b0}};
         ym_r     <= {MW{1'b0}};
         prod_r   <= {PW{1'b0}};
         frac_r   <= {FRAC_W{1'b0}};
         guard_r  <= 1'b0;
         sticky_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               dv_r <= 1'b0;
               if (bus.data_valid_i && ready_r) begin
                  sign_r  <= bus.x_i[W-1] ^ bus.y_i[W-1];
                  xcls_r  <= x_cls_s;
                  ycls_r  <= y_cls_s;
                  exp_r   <= $signed({2'b00, x_exp_s}) + $signed({2'b00, y_exp_s}) - BIAS_S;
                  xm_r    <= {1'b1, x_frac_s};
                  ym_r    <= {1'b1, y_frac_s};
                  ready_r <= 1'b0;
                  state_r <= ST_MUL;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_MUL: begin
               prod_r  <= {{MW{1'b0}}, xm_r} * {{MW{1'b0}}, ym_r};
               state_r <= ST_NORM;
            end
            ST_NORM: begin
               frac_r   <= norm_frac_s;
               guard_r  <= norm_guard_s;
               sticky_r <= norm_sticky_s;
               exp_r    <= norm_exp_s;
               state_r  <= ST_ROUND;
            end
            ST_ROUND: begin
               z_r     <= res_z_s;
               inv_r   <= res_inv_s;
               ovf_r   <= res_ovf_s;
               unf_r   <= res_unf_s;
               inx_r   <= res_inx_s;
               dv_r    <= 1'b1;
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               dv_r    <= 1'b0;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               dv_r    <= 1'b0;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o                    = ready_r;
   assign bus.data_valid_o               = dv_r;
   assign bus.z_o                        = z_r;
   assign bus.except_invalid_operation_o = inv_r;
   assign bus.except_overflow_o          = ovf_r;
   assign bus.except_underflow_o         = unf_r;
   assign bus.except_inexact_o           = inx_r;

endmodule

// File: tb/tb_fpu_multiplier_rne.sv
// -----------------------------------------------------------------------------
// tb_fpu_multiplier_rne
// Directed self-checking bench for fpu_multiplier_rne at binary32 defaults.
// Flags are grouped as {invalid, overflow, underflow, inexact}.
// -----------------------------------------------------------------------------
module tb_fpu_multiplier_rne;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int W      = 1 + EXP_W + FRAC_W;

`ifdef FPU_MUL_ROUND_EN
   localparam logic [31:0] Z_TIE = 32'h40100002;
`else
   localparam logic [31:0] Z_TIE = 32'h40100001;
`endif

   typedef struct packed {
      logic        timeout;
      logic        dv_pre;
      logic        rdy_pre;
      logic        dv_done;
      logic [31:0] z;
      logic [3:0]  f;
      logic        dv_post;
      logic        rdy_post;
      logic [31:0] z_post;
   } obs_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   errors = 0;
   int   checks = 0;

   fpu_multiplier_rne_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

   fpu_multiplier_rne #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   // Stimulus tables: x, y, expected z, expected flags.
   localparam int NA = 5;
   localparam logic [31:0] AX [NA] = '{32'h40000000, 32'hC0000000, 32'h3FC00001, 32'h3FFFFFFF, 32'h3F800000};
   localparam logic [31:0] AY [NA] = '{32'h40400000, 32'h40400000, 32'h3FC00001, 32'h3FFFFFFF, 32'h3F800000};
   localparam logic [31:0] AZ [NA] = '{32'h40C00000, 32'hC0C00000, Z_TIE,        32'h407FFFFE, 32'h3F800000};
   localparam logic [3:0]  AF [NA] = '{4'b0000,      4'b0000,      4'b0001,      4'b0001,      4'b0000};

   localparam int NR = 3;
   localparam logic [31:0] RX [NR] = '{32'h7F000000, 32'h00800000, 32'hFF000000};
   localparam logic [31:0] RY [NR] = '{32'h7F000000, 32'h00800000, 32'h7F000000};
   localparam logic [31:0] RZ [NR] = '{32'h7F800000, 32'h00000000, 32'hFF800000};
   localparam logic [3:0]  RF [NR] = '{4'b0101,      4'b0011,      4'b0101};

   localparam int NS = 6;
   localparam logic [31:0] SX [NS] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000, 32'h00000001};
   localparam logic [31:0] SY [NS] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h7F800000, 32'h40000000};
   localparam logic [31:0] SZ [NS] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFF800000, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
   localparam logic [3:0]  SF [NS] = '{4'b1000,      4'b1000,      4'b0000,      4'b0000,      4'b1000,      4'b0000};

   function automatic logic [3:0] flags_now();
      return {bus.except_invalid_operation_o, bus.except_overflow_o,
              bus.except_underflow_o, bus.except_inexact_o};
   endfunction

   // Drives one operation from a negedge in IDLE and records observations.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, output obs_t o);
      int waited;
      waited = 0;
      o = '0;
      while (bus.ready_o !== 1'b1 && waited < 20) begin
         @(negedge clk_i);
         waited++;
      end
      o.timeout = (bus.ready_o !== 1'b1);
      bus.x_i = x;
      bus.y_i = y;
      bus.data_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.data_valid_i = 1'b0;
      bus.x_i = ~x;
      bus.y_i = ~y;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      o.dv_pre  = bus.data_valid_o;
      o.rdy_pre = bus.ready_o;
      @(negedge clk_i);
      o.dv_done = bus.data_valid_o;
      o.z       = bus.z_o;
      o.f       = flags_now();
      @(negedge clk_i);
      o.dv_post  = bus.data_valid_o;
      o.rdy_post = bus.ready_o;
      o.z_post   = bus.z_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      bus.data_valid_i = 1'b0;
      bus.x_i = '0;
      bus.y_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
      checks++;
      if (bus.data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.data_valid_o); end
      checks++;
      if (bus.z_o !== 32'h0) begin errors++; $display("FAIL reset_z got %h want 00000000", bus.z_o); end
      checks++;
      if (flags_now() !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags_now()); end
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_arith();
      obs_t o;
      for (int i = 0; i < NA; i++) begin
         do_op(AX[i], AY[i], o);
         checks++;
         if (o.timeout || o.dv_pre !== 1'b0 || o.rdy_pre !== 1'b0 || o.dv_done !== 1'b1 || o.dv_post !== 1'b0 || o.rdy_post !== 1'b1) begin
            errors++;
            $display("FAIL arith[%0d]_timing got to=%b pre=%b rdy=%b done=%b post=%b rdy_post=%b want 0 0 0 1 0 1",
                     i, o.timeout, o.dv_pre, o.rdy_pre, o.dv_done, o.dv_post, o.rdy_post);
         end
         checks++;
         if (o.z !== AZ[i]) begin errors++; $display("FAIL arith[%0d]_z got %h want %h", i, o.z, AZ[i]); end
         checks++;
         if (o.f !== AF[i]) begin errors++; $display("FAIL arith[%0d]_flags got %b want %b", i, o.f, AF[i]); end
         checks++;
         if (o.z_post !== AZ[i]) begin errors++; $display("FAIL arith[%0d]_hold got %h want %h", i, o.z_post, AZ[i]); end
      end
   endtask

   task automatic test_range();
      obs_t o;
      for (int i = 0; i < NR; i++) begin
         do_op(RX[i], RY[i], o);
         checks++;
         if (o.timeout || o.dv_done !== 1'b1 || o.dv_pre !== 1'b0) begin
            errors++;
            $display("FAIL range[%0d]_timing got to=%b pre=%b done=%b want 0 0 1", i, o.timeout, o.dv_pre, o.dv_done);
         end
         checks++;
         if (o.z !== RZ[i]) begin errors++; $display("FAIL range[%0d]_z got %h want %h", i, o.z, RZ[i]); end
         checks++;
         if (o.f !== RF[i]) begin errors++; $display("FAIL range[%0d]_flags got %b want %b", i, o.f, RF[i]); end
      end
   endtask

   task automatic test_special();
      obs_t o;
      for (int i = 0; i < NS; i++) begin
         do_op(SX[i], SY[i], o);
         checks++;
         if (o.timeout || o.dv_done !== 1'b1 || o.dv_pre !== 1'b0 || o.dv_post !== 1'b0) begin
            errors++;
            $display("FAIL special[%0d]_timing got to=%b pre=%b done=%b post=%b want 0 0 1 0",
                     i, o.timeout, o.dv_pre, o.dv_done, o.dv_post);
         end
         checks++;
         if (o.z !== SZ[i]) begin errors++; $display("FAIL special[%0d]_z got %h want %h", i, o.z, SZ[i]); end
         checks++;
         if (o.f !== SF[i]) begin errors++; $display("FAIL special[%0d]_flags got %b want %b", i, o.f, SF[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int   pulses;
      obs_t o;
      pulses = 0;
      bus.x_i = 32'h40000000;
      bus.y_i = 32'h40400000;
      bus.data_valid_i = 1'b1;
      @(posedge clk_i);          // accept
      #1 bus.data_valid_i = 1'b0;
      @(posedge clk_i);          // now in NORM
      #1 rst_i = 1'b1;
      @(posedge clk_i);          // reset taken
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.ready_o); end
      checks++;
      if (bus.z_o !== 32'h0 || flags_now() !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_cleared got z=%h flags=%b want 00000000 0000", bus.z_o, flags_now());
      end
      for (int k = 0; k < 6; k++) begin
         if (bus.data_valid_o === 1'b1) pulses++;
         @(negedge clk_i);
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d pulses want 0", pulses); end
      do_op(32'h40000000, 32'h40400000, o);
      checks++;
      if (o.timeout || o.dv_done !== 1'b1 || o.z !== 32'h40C00000) begin
         errors++;
         $display("FAIL rstmid_recover got to=%b done=%b z=%h want 0 1 40c00000", o.timeout, o.dv_done, o.z);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      bus.x_i = 32'h40000000;
      bus.y_i = 32'h40400000;
      bus.data_valid_i = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk_i);       // after edge k; edge 0 is the first accept
         checks++;
         if (bus.ready_o !== ((k % 5) == 4)) begin
            errors++;
            $display("FAIL b2b_ready[%0d] got %b want %b", k, bus.ready_o, ((k % 5) == 4));
         end
         checks++;
         if (bus.data_valid_o !== ((k % 5) == 3)) begin
            errors++;
            $display("FAIL b2b_valid[%0d] got %b want %b", k, bus.data_valid_o, ((k % 5) == 3));
         end
         if (bus.data_valid_o === 1'b1) begin
            pulses++;
            checks++;
            if (bus.z_o !== 32'h40C00000) begin errors++; $display("FAIL b2b_z[%0d] got %h want 40c00000", k, bus.z_o); end
         end
      end
      bus.data_valid_i = 1'b0;
      checks++;
      if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
      repeat (6) @(negedge clk_i);
   endtask

   initial begin
      bus.data_valid_i = 1'b0;
      bus.x_i = '0;
      bus.y_i = '0;
      test_reset();
      test_arith();
      test_range();
      test_special();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
